// File: rtl/reg_bank_wb_sched.sv
// Writeback scheduler for the register bank's single write port: round-robin
// arbitration of ALU/load writebacks, registered write stage, pending-write scoreboard.
module reg_bank_wb_sched #(
  parameter int DIR_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DIR_WIDTH-1:0]  req0_dir,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DIR_WIDTH-1:0]  req1_dir,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  reserve_en,
  input  logic [DIR_WIDTH-1:0]  reserve_dir,
  output logic                  reserve_stall,
  input  logic [DIR_WIDTH-1:0]  read_dir1,
  input  logic [DIR_WIDTH-1:0]  read_dir2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  write_en,
  output logic [DIR_WIDTH-1:0]  write_dir,
  output logic [DATA_WIDTH-1:0] write_data
);

  localparam int NUM_REGS = 2**DIR_WIDTH;

  logic                  rr_ptr;
  logic                  grant0_p0;
  logic                  grant1_p0;
  logic                  vld_p0;
  logic [DIR_WIDTH-1:0]  dir_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;
  logic                  commit_live;

  // Stage p0: combinational arbitration, one grant per cycle at most
  always_comb begin
    grant0_p0 = req0_valid && (!req1_valid || !rr_ptr);
    grant1_p0 = req1_valid && (!req0_valid ||  rr_ptr);
    dir_p0    = grant1_p0 ? req1_dir  : req0_dir;
    data_p0   = grant1_p0 ? req1_data : req0_data;
    // A grant to x0 is accepted but never reaches the write stage
    vld_p0    = (grant0_p0 || grant1_p0) && (dir_p0 != '0);
  end

  assign req0_ready = grant0_p0;
  assign req1_ready = grant1_p0;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (grant0_p0)
      rr_ptr <= 1'b1;
    else if (grant1_p0)
      rr_ptr <= 1'b0;
  end

  // Stage p1: registered bank write port
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_dir  <= '0;
      write_data <= '0;
    end else begin
      write_en <= vld_p0;
      if (vld_p0) begin
        write_dir  <= dir_p0;
        write_data <= data_p0;
      end
    end
  end

  // Scoreboard: a reservation landing on the register being committed survives
  assign commit_live = write_en && (write_dir != '0);

  always_comb begin
    pending_next = pending;
    if (commit_live)
      pending_next[write_dir] = 1'b0;
    if (reserve_en && (reserve_dir != '0))
      pending_next[reserve_dir] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_next;
  end

  // The bank forwards write_data, so the register being committed reads as ready
  always_comb begin
    reserve_stall = reserve_en && pending[reserve_dir] &&
                    !(write_en && (write_dir == reserve_dir));
    busy1 = pending[read_dir1] && !(write_en && (write_dir == read_dir1));
    busy2 = pending[read_dir2] && !(write_en && (write_dir == read_dir2));
  end

endmodule

// File: tb/tb_reg_bank_wb_sched.sv
// Self-checking bench for reg_bank_wb_sched: directed vector table followed by
// randomized traffic compared against a rule-level reference model.
module tb_reg_bank_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_dir, req1_dir, reserve_dir, read_dir1, read_dir2, write_dir;
  logic [31:0] req0_data, req1_data, write_data;
  logic        reserve_en, reserve_stall, busy1, busy2, write_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_bank_wb_sched #(.DIR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_data(req1_data), .req1_ready(req1_ready),
    .reserve_en(reserve_en), .reserve_dir(reserve_dir), .reserve_stall(reserve_stall),
    .read_dir1(read_dir1), .read_dir2(read_dir2), .busy1(busy1), .busy2(busy2),
    .write_en(write_en), .write_dir(write_dir), .write_data(write_data)
  );

  typedef struct {
    logic        rst;
    logic        v0;  logic [4:0] d0; logic [31:0] x0;
    logic        v1;  logic [4:0] d1; logic [31:0] x1;
    logic        re;  logic [4:0] rdir;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        chk; logic chkw;
    logic        e_rdy0, e_rdy1, e_st, e_b1, e_b2, e_we;
    logic [4:0]  e_wd; logic [31:0] e_wx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs, input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                     input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                     input logic re, input logic [4:0] rdir, input logic [4:0] r1, input logic [4:0] r2,
                     input logic chk, input logic chkw,
                     input logic er0, input logic er1, input logic est, input logic eb1, input logic eb2,
                     input logic ewe, input logic [4:0] ewd, input logic [31:0] ewx);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.d0 = d0; v.x0 = x0; v.v1 = v1; v.d1 = d1; v.x1 = x1;
    v.re = re; v.rdir = rdir; v.r1 = r1; v.r2 = r2; v.chk = chk; v.chkw = chkw;
    v.e_rdy0 = er0; v.e_rdy1 = er1; v.e_st = est; v.e_b1 = eb1; v.e_b2 = eb2;
    v.e_we = ewe; v.e_wd = ewd; v.e_wx = ewx;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                       input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                       input logic re, input logic [4:0] rdir, input logic [4:0] r1, input logic [4:0] r2);
    rst = rs; req0_valid = v0; req0_dir = d0; req0_data = x0;
    req1_valid = v1; req1_dir = d1; req1_data = x1;
    reserve_en = re; reserve_dir = rdir; read_dir1 = r1; read_dir2 = r2;
  endtask

  // Reference model state: register-level view of the scheduler
  bit          m_pend[32];
  int          m_prefer;
  bit          m_we;
  logic [4:0]  m_wd;
  logic [31:0] m_wx;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_prefer = 0; m_we = 1'b0; m_wd = '0; m_wx = '0;
  endtask

  initial begin
    int winner;
    logic rs, v0, v1, re;
    logic [4:0] d0, d1, rdir, r1, r2;
    logic [31:0] x0, x1;
    bit e_rdy0, e_rdy1, e_st, e_b1, e_b2;

    //   rst v0 d0  x0           v1 d1  x1        re rdir r1 r2  chk chkw r0 r1 st b1 b2 we wd  wx
    add(1, 0, 0,  0,           0, 0,  0,        0, 0,   0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0,  0);
    add(1, 0, 0,  0,           0, 0,  0,        0, 0,   0, 0,  1, 1,  0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   0, 0,  1, 1,  0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 1, 3,  32'hA,       1, 4,  32'hB,    0, 0,   0, 0,  1, 1,  1, 0, 0, 0, 0, 0, 0,  0);
    add(0, 1, 3,  32'hA,       1, 4,  32'hB,    0, 0,   0, 0,  1, 1,  0, 1, 0, 0, 0, 1, 3,  32'hA);
    add(0, 1, 3,  32'hA,       1, 4,  32'hB,    0, 0,   0, 0,  1, 1,  1, 0, 0, 0, 0, 1, 4,  32'hB);
    add(0, 1, 3,  32'hA,       1, 4,  32'hB,    0, 0,   0, 0,  1, 1,  0, 1, 0, 0, 0, 1, 3,  32'hA);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   0, 0,  1, 1,  0, 0, 0, 0, 0, 1, 4,  32'hB);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   0, 0,  1, 1,  0, 0, 0, 0, 0, 0, 4,  32'hB);
    add(0, 0, 0,  0,           0, 0,  0,        1, 7,   7, 0,  1, 1,  0, 0, 0, 0, 0, 0, 4,  32'hB);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   7, 7,  1, 1,  0, 0, 0, 1, 1, 0, 4,  32'hB);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   7, 0,  1, 1,  0, 0, 0, 1, 0, 0, 4,  32'hB);
    add(0, 0, 0,  0,           1, 7,  32'h55,   0, 0,   7, 0,  1, 1,  0, 1, 0, 1, 0, 0, 4,  32'hB);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   7, 0,  1, 1,  0, 0, 0, 0, 0, 1, 7,  32'h55);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   7, 0,  1, 1,  0, 0, 0, 0, 0, 0, 7,  32'h55);
    add(0, 1, 0,  32'hFFFFFFFF,0, 0,  0,        0, 0,   7, 0,  1, 1,  1, 0, 0, 0, 0, 0, 7,  32'h55);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   7, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 0, 0,  0,           0, 0,  0,        1, 5,   0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 0, 0,  0,           0, 0,  0,        1, 5,   0, 0,  1, 0,  0, 0, 1, 0, 0, 0, 0,  0);
    add(0, 1, 5,  32'h77,      0, 0,  0,        0, 0,   5, 0,  1, 0,  1, 0, 0, 1, 0, 0, 0,  0);
    add(0, 0, 0,  0,           0, 0,  0,        1, 5,   5, 0,  1, 1,  0, 0, 0, 0, 0, 1, 5,  32'h77);
    add(0, 0, 0,  0,           0, 0,  0,        1, 5,   5, 0,  1, 1,  0, 0, 1, 1, 0, 0, 5,  32'h77);
    add(0, 1, 9,  32'h99,      0, 0,  0,        1, 9,   9, 0,  1, 1,  1, 0, 0, 0, 0, 0, 5,  32'h77);
    add(1, 0, 0,  0,           0, 0,  0,        0, 0,   9, 0,  1, 1,  0, 0, 0, 0, 0, 1, 9,  32'h99);
    add(0, 1, 10, 32'h10,      1, 11, 32'h11,   0, 0,   5, 9,  1, 1,  1, 0, 0, 0, 0, 0, 0,  0);
    add(0, 0, 0,  0,           0, 0,  0,        0, 0,   0, 0,  1, 1,  0, 0, 0, 0, 0, 1, 10, 32'h10);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].x0, tbl[i].v1, tbl[i].d1, tbl[i].x1,
            tbl[i].re, tbl[i].rdir, tbl[i].r1, tbl[i].r2);
      #2;
      if (tbl[i].chk) begin
        chk($sformatf("row%0d req0_ready", i), req0_ready, tbl[i].e_rdy0);
        chk($sformatf("row%0d req1_ready", i), req1_ready, tbl[i].e_rdy1);
        chk($sformatf("row%0d reserve_stall", i), reserve_stall, tbl[i].e_st);
        chk($sformatf("row%0d busy1", i), busy1, tbl[i].e_b1);
        chk($sformatf("row%0d busy2", i), busy2, tbl[i].e_b2);
        chk($sformatf("row%0d write_en", i), write_en, tbl[i].e_we);
        if (tbl[i].chkw) begin
          chk($sformatf("row%0d write_dir", i), write_dir, tbl[i].e_wd);
          chk($sformatf("row%0d write_data", i), write_data, tbl[i].e_wx);
        end
      end
      @(posedge clk); #1;
    end

    // Random phase: one reset cycle aligns the model, then free-running traffic
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      rs   = ($urandom_range(0, 99) == 0);
      v0   = $urandom_range(0, 1);   d0 = 5'($urandom_range(0, 7));   x0 = $urandom;
      v1   = $urandom_range(0, 1);   d1 = 5'($urandom_range(0, 7));   x1 = $urandom;
      re   = ($urandom_range(0, 2) == 0); rdir = 5'($urandom_range(0, 7));
      r1   = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      drive(rs, v0, d0, x0, v1, d1, x1, re, rdir, r1, r2);

      winner = -1;
      if (v0 && v1) winner = m_prefer;
      else if (v0)  winner = 0;
      else if (v1)  winner = 1;
      e_rdy0 = (winner == 0);
      e_rdy1 = (winner == 1);
      e_st = re && m_pend[rdir] && !(m_we && m_wd == rdir);
      e_b1 = m_pend[r1] && !(m_we && m_wd == r1);
      e_b2 = m_pend[r2] && !(m_we && m_wd == r2);

      #2;
      chk($sformatf("rand%0d req0_ready", c), req0_ready, e_rdy0);
      chk($sformatf("rand%0d req1_ready", c), req1_ready, e_rdy1);
      chk($sformatf("rand%0d reserve_stall", c), reserve_stall, e_st);
      chk($sformatf("rand%0d busy1", c), busy1, e_b1);
      chk($sformatf("rand%0d busy2", c), busy2, e_b2);
      chk($sformatf("rand%0d write_en", c), write_en, m_we);
      if (m_we) begin
        chk($sformatf("rand%0d write_dir", c), write_dir, m_wd);
        chk($sformatf("rand%0d write_data", c), write_data, m_wx);
      end

      if (rs) begin
        model_reset();
      end else begin
        if (m_we && m_wd != 0) m_pend[m_wd] = 1'b0;
        if (re && rdir != 0)   m_pend[rdir] = 1'b1;
        m_we = 1'b0;
        if (winner >= 0) begin
          m_prefer = 1 - winner;
          if ((winner == 0 ? d0 : d1) != 0) begin
            m_we = 1'b1;
            m_wd = (winner == 0) ? d0 : d1;
            m_wx = (winner == 0) ? x0 : x1;
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_wb_sched.md
Name: reg_bank_wb_sched

Overview:
- Writeback scheduler in front of the register bank's single write port (write_en/write_dir/write_data).
- Arbitrates round-robin between two writeback requesters: requester 0 = ALU, requester 1 = load unit.
- Drives the bank write port from a registered output stage.
- Keeps a pending-write scoreboard (one bit per register) so the decode stage can stall reads of registers whose writeback is outstanding.

Parameters:
- DIR_WIDTH, 5, register address width; NUM_REGS = 2**DIR_WIDTH (derived, not overridable).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  requester 0 has a writeback.
- req0_dir  input  DIR_WIDTH  requester 0 destination register.
- req0_data  input  DATA_WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 writeback accepted this cycle.
- req1_valid  input  1  requester 1 has a writeback.
- req1_dir  input  DIR_WIDTH  requester 1 destination register.
- req1_data  input  DATA_WIDTH  requester 1 write data.
- req1_ready  output  1  requester 1 writeback accepted this cycle.
- reserve_en  input  1  issue stage reserves a destination register.
- reserve_dir  input  DIR_WIDTH  register being reserved.
- reserve_stall  output  1  reserve_dir already pending (WAW hazard); combinational.
- read_dir1  input  DIR_WIDTH  decode read address 1.
- read_dir2  input  DIR_WIDTH  decode read address 2.
- busy1  output  1  read_dir1 has an outstanding write that is not being committed this cycle.
- busy2  output  1  same, for read_dir2.
- write_en  output  1  bank write enable (registered).
- write_dir  output  DIR_WIDTH  bank write address (registered).
- write_data  output  DATA_WIDTH  bank write data (registered).

Behaviour:
- Reset (rst high at a clock edge): write_en=0, write_dir=0, write_data=0, pending=0, rr_ptr=0 (requester 0 has priority). rst overrides every simultaneous grant, reserve and commit.
- Arbitration is combinational; at most one grant per cycle.
  - Only one requester valid: grant it.
  - Both valid: grant the requester selected by rr_ptr.
  - req_ready_i = grant_i. ready never depends on ready, so there is no combinational loop.
  - No stall path: the output stage is always free, so one accept per cycle is sustained.
- rr_ptr update: after any grant, rr_ptr <= index of the requester not granted. With no grant, rr_ptr holds.
- Output stage:
  - Grant in cycle N with dir != 0: write_en=1, write_dir=dir, write_data=data in cycle N+1. The bank commits at the end of N+1.
  - No grant in N: write_en=0 in N+1; write_dir and write_data hold their previous values.
- x0 handling: a grant with dir == 0 is accepted (ready=1) and dropped. write_en stays 0 and the scoreboard is untouched.
- Scoreboard (pending[NUM_REGS-1:0], bit 0 constant 0):
  - Set: reserve_en && reserve_dir != 0 sets pending[reserve_dir] at the next edge.
  - Clear: write_en && write_dir != 0 clears pending[write_dir] at the next edge.
  - Set and clear on the same register in the same cycle: set wins (the new reservation survives).
  - A writeback to a non-pending register is legal and leaves pending unchanged.
- reserve_stall = reserve_en && pending[reserve_dir] && !(write_en && write_dir == reserve_dir).
  - When reserve_stall is high, the reserve is ignored; the bit is already 1.
  - The issuer must hold reserve_en until reserve_stall is low.
- busy_k = pending[read_dir_k] && !(write_en && write_dir == read_dir_k).
  - The bank forwards write_data when the read address equals write_dir, so a register being committed this cycle is not busy.
  - read_dir_k == 0 always gives busy_k = 0.
- Reset mid-operation: in-flight output-stage writes are discarded (write_en=0 next cycle) and all reservations are lost.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then inputs idle -> write_en=0, busy1=busy2=0, reserve_stall=0, both ready=0.
- Contention round-robin: req0(dir 3, 0xA) and req1(dir 4, 0xB) held valid 4 cycles from reset ->
  - grants ordered 0,1,0,1;
  - write_en=1 from cycle 2 with write_dir sequence 3,4,3,4.
- Scoreboard life cycle: reserve x7 in cycle 0; req1 writes x7=0x55 in cycle 3 ->
  - busy1 (read_dir1=7) is 1 in cycles 1..3;
  - busy1 is 0 in cycle 4 (commit cycle, write_en=1, write_dir=7);
  - pending[7]=0 from cycle 5.
- x0 write: req0 valid dir 0, data 0xFFFF_FFFF -> req0_ready=1, write_en stays 0, pending unchanged.
- WAW and set-wins:
  - reserve x5 twice in back-to-back cycles -> second cycle reserve_stall=1.
  - Reserve x5 in the cycle its commit is presented (write_en=1, write_dir=5) -> reserve_stall=0 and pending[5] stays 1 afterwards.
- Reset mid-flight: grant req0 (dir 9), assert rst in the next cycle -> write_en=0 the following cycle, pending=0, rr_ptr=0 (req0 wins next contention).
